// File: rtl/sd_mod_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | sd_mod_pkg : shared constants and saturating arithmetic for sd_mod      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package sd_mod_pkg;

   localparam int DW_DEFAULT  = 12;
   localparam int I1W_DEFAULT = 16;
   localparam int I2W_DEFAULT = 18;

   localparam int FS = 2 ** (DW_DEFAULT - 1);

   localparam logic [1:0] PH_I  = 2'd0;
   localparam logic [1:0] PH_NQ = 2'd1;
   localparam logic [1:0] PH_NI = 2'd2;
   localparam logic [1:0] PH_Q  = 2'd3;

   // Fibonacci taps for x^16+x^14+x^13+x^11+1 with a right-shifting register
   localparam logic [15:0] LFSR_TAPS = 16'h002D;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Operands are far below 2^31, so the 32-bit sum itself never wraps.
   function automatic logic signed [31:0] sat_add(
      input logic signed [31:0] a,
      input logic signed [31:0] b,
      input int                 width
   );
      logic signed [31:0] s;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      s  = a + b;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (s > hi)
         sat_add = hi;
      else if (s < lo)
         sat_add = lo;
      else
         sat_add = s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sd_mod_loop.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | sd_mod_loop : second-order saturating integrator pair and 1-bit quantizer|
// | Optional dither via SDMOD_DITHER_EN. Rev 1.0                           |
// +------------------------------------------------------------------------+
module sd_mod_loop
   import sd_mod_pkg::*;
#(
   parameter int DW  = DW_DEFAULT,
   parameter int I1W = I1W_DEFAULT,
   parameter int I2W = I2W_DEFAULT
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic signed [DW-1:0] x,
   output logic                 q
);

   localparam logic signed [31:0] FULL = 32'sd1 <<< (DW - 1);

   logic signed [I1W-1:0] i1;
   logic signed [I2W-1:0] i2;
   logic                  fb_en;
   logic signed [31:0]    v;
   logic signed [31:0]    i1n;
   logic signed [31:0]    i2n;
   logic signed [31:0]    dec;

`ifdef SDMOD_DITHER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= LFSR_SEED;
      else if (en)
         lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
   end
`endif

   always_comb begin
      v = 32'sd0;
      if (fb_en)
         v = q ? FULL : -FULL;
      i1n = sat_add(32'(i1), 32'(x) - v, I1W);
      i2n = sat_add(32'(i2), i1n - v, I2W);
`ifdef SDMOD_DITHER_EN
      dec = i2n + (lfsr[0] ? 32'sd1 : -32'sd1);
`else
      dec = i2n;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i1    <= '0;
         i2    <= '0;
         q     <= 1'b0;
         fb_en <= 1'b0;
      end else if (en) begin
         i1    <= i1n[I1W-1:0];
         i2    <= i2n[I2W-1:0];
         q     <= ~dec[31];
         fb_en <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sd_mod.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | sd_mod : fs/4 upconverter + second-order 1-bit sigma-delta modulator   |
// | Optional LFSR dither via SDMOD_DITHER_EN. Rev 1.0                      |
// +------------------------------------------------------------------------+
module sd_mod
   import sd_mod_pkg::*;
#(
   parameter int DW  = DW_DEFAULT,
   parameter int I1W = I1W_DEFAULT,
   parameter int I2W = I2W_DEFAULT
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [DW-1:0] di_re,
   input  logic signed [DW-1:0] di_im,
   input  logic                 di_vld,
   output logic                 do_bit,   // modulator bit ("do" is a reserved word)
   output logic                 do_vld
);

   localparam logic signed [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

   logic [1:0]           ph;
   logic signed [DW-1:0] x;

   function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] a);
      return (a == MIN_NEG) ? MAX_POS : -a;
   endfunction

   // Phase restarts at 0 on any idle cycle so every burst begins on the I branch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ph <= 2'd0;
      else if (di_vld)
         ph <= ph + 2'd1;
      else
         ph <= 2'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         do_vld <= 1'b0;
      else
         do_vld <= di_vld;
   end

   always_comb begin
      x = di_re;
      case (ph)
         PH_I:    x = di_re;
         PH_NQ:   x = neg_sat(di_im);
         PH_NI:   x = neg_sat(di_re);
         PH_Q:    x = di_im;
         default: x = di_re;
      endcase
   end

   sd_mod_loop #(
      .DW  (DW),
      .I1W (I1W),
      .I2W (I2W)
   ) u_loop (
      .clk (clk),
      .rst (rst),
      .en  (di_vld),
      .x   (x),
      .q   (do_bit)
   );

endmodule
`default_nettype wire

// File: tb/tb_sd_mod.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sd_mod : directed self-checking bench for sd_mod                    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_sd_mod;

   logic              clk = 1'b0;
   logic              rst;
   logic signed [11:0] di_re;
   logic signed [11:0] di_im;
   logic              di_vld;
   logic              do_bit;
   logic              do_vld;

   int vectors     = 0;
   int miscompares = 0;

   int m_i1, m_i2, m_do, m_fb, m_ph, m_lfsr;

   int ones, run, max_run, pulses;
   int last_bit;

   always #5 clk = ~clk;

   sd_mod u_dut (
      .clk    (clk),
      .rst    (rst),
      .di_re  (di_re),
      .di_im  (di_im),
      .di_vld (di_vld),
      .do_bit (do_bit),
      .do_vld (do_vld)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int clamp(input int val, input int w);
      int hi, lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      return (val > hi) ? hi : ((val < lo) ? lo : val);
   endfunction

   task automatic model_reset();
      m_i1 = 0; m_i2 = 0; m_do = 0; m_fb = 0; m_ph = 0; m_lfsr = 16'hACE1;
   endtask

   task automatic model_step(input int vld, input int re, input int im);
      int x, v, d, b;
      if (vld != 0) begin
         case (m_ph)
            0: x = re;
            1: x = -im;
            2: x = -re;
            default: x = im;
         endcase
         if (x > 2047) x = 2047;
         v = (m_fb != 0) ? ((m_do != 0) ? 2048 : -2048) : 0;
         m_i1 = clamp(m_i1 + x - v, 16);
         m_i2 = clamp(m_i2 + m_i1 - v, 18);
`ifdef SDMOD_DITHER_EN
         d = ((m_lfsr & 1) != 0) ? 1 : -1;
         b = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
         m_lfsr = (m_lfsr >> 1) | (b << 15);
`else
         d = 0;
         b = 0;
`endif
         m_do = (m_i2 + d >= 0) ? 1 : 0;
         m_fb = 1;
         m_ph = (m_ph + 1) % 4;
      end else begin
         m_ph = 0;
      end
   endtask

   // Drive one cycle of input, then compare the registered outputs after the edge.
   task automatic apply(input string tag, input int vld, input int re, input int im);
      di_vld = (vld != 0);
      di_re  = 12'(re);
      di_im  = 12'(im);
      @(posedge clk);
      #1;
      model_step(vld, re, im);
      check({tag, "_vld"}, 32'(do_vld), 32'(vld != 0));
      check({tag, "_do"},  32'(do_bit), 32'(m_do));
   endtask

   initial begin
      rst    = 1'b1;
      di_vld = 1'b0;
      di_re  = '0;
      di_im  = '0;
      model_reset();

      // Reset hold with random traffic on the inputs
      for (int i = 0; i < 10; i++) begin
         di_vld = 1'($urandom_range(0, 1));
         di_re  = 12'($urandom);
         di_im  = 12'($urandom);
         @(posedge clk);
         #1;
         check("rst_hold_vld", 32'(do_vld), 32'd0);
         check("rst_hold_do",  32'(do_bit), 32'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) apply("post_rst_idle", 0, 0, 0);

      // Zero input burst
      ones = 0; run = 0; max_run = 0; pulses = 0; last_bit = -1;
      for (int i = 0; i < 512; i++) begin
         apply("zero", 1, 0, 0);
         if (do_vld) begin
            pulses++;
            if (do_bit) ones++;
            run = (32'(do_bit) == last_bit) ? run + 1 : 1;
            last_bit = 32'(do_bit);
            if (run > max_run) max_run = run;
         end
      end
      apply("zero_tail", 0, 0, 0);
      check("zero_pulses", 32'(pulses), 32'd512);
      check("zero_ones_in_range", 32'((ones >= 254) && (ones <= 258)), 32'd1);
      check("zero_max_run_le2", 32'(max_run <= 2), 32'd1);

      // fs/4 tone
      for (int i = 0; i < 512; i++) apply("tone", 1, 1024, 0);
      apply("tone_tail", 0, 0, 0);

      // Full-scale negative input exercises negation saturation and integrator clamps
      for (int i = 0; i < 512; i++) apply("sat", 1, -2048, -2048);
      apply("sat_tail", 0, 0, 0);

      // Gapped valid: phase restarts, integrators hold
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         apply("gap_a", 1, 700, -300);
         if (do_vld) pulses++;
      end
      for (int i = 0; i < 3; i++) begin
         apply("gap_idle", 0, 700, -300);
         if (do_vld) pulses++;
      end
      for (int i = 0; i < 10; i++) begin
         apply("gap_b", 1, 700, -300);
         if (do_vld) pulses++;
      end
      check("gap_pulses", 32'(pulses), 32'd20);
      apply("gap_tail", 0, 0, 0);

      // Mid-burst asynchronous reset
      for (int i = 0; i < 200; i++) apply("mid", 1, 1024, 512);
      #3;
      rst    = 1'b1;
      di_vld = 1'b0;
      #1;
      check("async_rst_vld", 32'(do_vld), 32'd0);
      check("async_rst_do",  32'(do_bit), 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 64; i++) apply("after_rst", 1, 1024, 512);
      apply("after_rst_tail", 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
